// File: rtl/layer_sequencer_if.sv
// AddressGenerator bus: descriptor fields and load strobe out of the sequencer,
// finished flag back from the address generator.
interface layer_sequencer_if;
    logic [7:0] ag_nk;
    logic [7:0] ag_weight_base;
    logic [7:0] ag_neuro_rbase;
    logic [7:0] ag_neuro_wbase;
    logic       ag_read;
    logic       ag_finished;

    modport master (
        output ag_nk, ag_weight_base, ag_neuro_rbase, ag_neuro_wbase, ag_read,
        input  ag_finished
    );

    modport slave (
        input  ag_nk, ag_weight_base, ag_neuro_rbase, ag_neuro_wbase, ag_read,
        output ag_finished
    );
endinterface

// File: rtl/layer_sequencer.sv
// Layer-level controller: walks a descriptor table, loads the AddressGenerator per layer and
// gates the MAC. Optional run_cycles counter is enabled by defining LAYER_SEQ_CYCLE_CNT_EN.
module layer_sequencer #(
    parameter int unsigned MAX_LAYERS   = 8,
    parameter int unsigned DRAIN_CYCLES = 2,
    localparam int unsigned LW          = $clog2(MAX_LAYERS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_we,
    input  logic [LW-1:0]     cfg_addr,
    input  logic [7:0]        cfg_nk,
    input  logic [7:0]        cfg_wbase,
    input  logic [7:0]        cfg_rbase,
    input  logic [7:0]        cfg_wrbase,
    input  logic [LW:0]       num_layers,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [LW-1:0]     layer_idx,
    output logic              mac_clear,
    output logic              mac_en,
`ifdef LAYER_SEQ_CYCLE_CNT_EN
    output logic [15:0]       run_cycles,
`endif
    layer_sequencer_if.master ag
);

    localparam int unsigned DW        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DrainLast = DW'(DRAIN_CYCLES - 1);
    localparam logic [LW:0]   MinNl     = (LW+1)'(2);
    localparam logic [LW:0]   MaxNl     = (LW+1)'(MAX_LAYERS);

    typedef struct packed {
        logic [7:0] nk;
        logic [7:0] wbase;
        logic [7:0] rbase;
        logic [7:0] wrbase;
    } desc_t;

    typedef enum logic [2:0] {StIdle, StPrime, StLoad, StRun, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [LW-1:0]   layer_idx_q, layer_idx_d;
    logic [LW:0]     nl_q, nl_d;
    logic            error_q, error_d;
    logic            run_first_q, run_first_d;
    logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
    desc_t           desc_q, desc_d;
    desc_t           table_q [MAX_LAYERS];
    desc_t           cfg_desc;
    desc_t           desc0;
    logic            table_we;
    logic            num_ok;
    logic [LW:0]     idx_plus1;
    logic [LW-1:0]   next_idx;

    assign cfg_desc  = '{nk: cfg_nk, wbase: cfg_wbase, rbase: cfg_rbase, wrbase: cfg_wrbase};
    assign table_we  = cfg_we && (state_q == StIdle);
    assign num_ok    = (num_layers >= MinNl) && (num_layers <= MaxNl);
    assign idx_plus1 = {1'b0, layer_idx_q} + (LW+1)'(1);
    assign next_idx  = idx_plus1[LW-1:0];
    // A write to entry 0 in the accept cycle must reach the PRIME load.
    assign desc0     = (cfg_we && (cfg_addr == '0)) ? cfg_desc : table_q[0];

    // Table is deliberately not reset.
    always_ff @(posedge clk) begin
        if (table_we) begin
            table_q[cfg_addr] <= cfg_desc;
        end
    end

    always_comb begin
        state_d     = state_q;
        layer_idx_d = layer_idx_q;
        nl_d        = nl_q;
        error_d     = error_q;
        run_first_d = 1'b0;
        drain_cnt_d = drain_cnt_q;
        desc_d      = desc_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (num_ok) begin
                        nl_d        = num_layers;
                        layer_idx_d = '0;
                        error_d     = 1'b0;
                        desc_d      = desc0;
                        state_d     = StPrime;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            StPrime: begin
                layer_idx_d = LW'(1);
                desc_d      = table_q[LW'(1)];
                state_d     = StLoad;
            end
            StLoad: begin
                run_first_d = 1'b1;
                state_d     = StRun;
            end
            StRun: begin
                // The first RUN cycle may still see the previous layer's finished flag.
                if (!run_first_q && ag.ag_finished) begin
                    drain_cnt_d = '0;
                    state_d     = StDrain;
                end
            end
            StDrain: begin
                if (drain_cnt_q == DrainLast) begin
                    if (idx_plus1 == nl_q) begin
                        state_d = StDone;
                    end else begin
                        layer_idx_d = next_idx;
                        desc_d      = table_q[next_idx];
                        state_d     = StLoad;
                    end
                end else begin
                    drain_cnt_d = drain_cnt_q + DW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            layer_idx_q <= '0;
            nl_q        <= '0;
            error_q     <= 1'b0;
            run_first_q <= 1'b0;
            drain_cnt_q <= '0;
            desc_q      <= '0;
        end else begin
            state_q     <= state_d;
            layer_idx_q <= layer_idx_d;
            nl_q        <= nl_d;
            error_q     <= error_d;
            run_first_q <= run_first_d;
            drain_cnt_q <= drain_cnt_d;
            desc_q      <= desc_d;
        end
    end

    assign busy              = (state_q != StIdle);
    assign done              = (state_q == StDone);
    assign error             = error_q;
    assign layer_idx         = layer_idx_q;
    assign mac_clear         = (state_q == StLoad);
    assign mac_en            = (state_q == StRun);
    assign ag.ag_read        = (state_q == StPrime) || (state_q == StLoad);
    assign ag.ag_nk          = desc_q.nk;
    assign ag.ag_weight_base = desc_q.wbase;
    assign ag.ag_neuro_rbase = desc_q.rbase;
    assign ag.ag_neuro_wbase = desc_q.wrbase;

`ifdef LAYER_SEQ_CYCLE_CNT_EN
    logic [15:0] cyc_cnt_q, cyc_cnt_d;

    // The accept cycle counts as the first busy cycle.
    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        if ((state_q == StIdle) && start && num_ok) begin
            cyc_cnt_d = 16'd1;
        end else if (busy && (cyc_cnt_q != 16'hFFFF)) begin
            cyc_cnt_d = cyc_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

    assign run_cycles = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: run-level reference model (expected strobe counts,
// descriptor order, busy length) plus a table of start/error vectors and reset corner cases.
module tb_layer_sequencer;
    localparam int MaxL  = 8;
    localparam int Drain = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [7:0] cfg_nk = '0, cfg_wbase = '0, cfg_rbase = '0, cfg_wrbase = '0;
    logic [3:0] num_layers = '0;
    logic       start = 1'b0;
    logic       busy, done, error, mac_clear, mac_en;
    logic [2:0] layer_idx;
`ifdef LAYER_SEQ_CYCLE_CNT_EN
    logic [15:0] run_cycles;
`endif

    layer_sequencer_if ag_bus();

    layer_sequencer #(.MAX_LAYERS(MaxL), .DRAIN_CYCLES(Drain)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_nk     (cfg_nk),
        .cfg_wbase  (cfg_wbase),
        .cfg_rbase  (cfg_rbase),
        .cfg_wrbase (cfg_wrbase),
        .num_layers (num_layers),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .layer_idx  (layer_idx),
        .mac_clear  (mac_clear),
        .mac_en     (mac_en),
`ifdef LAYER_SEQ_CYCLE_CNT_EN
        .run_cycles (run_cycles),
`endif
        .ag         (ag_bus.master)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] tbl [MaxL];

    typedef struct {
        int nl;
        bit err;
        bit bsy;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] out_vec();
        return {23'd0, busy, done, error, layer_idx, mac_clear, mac_en, ag_bus.ag_read,
                ag_bus.ag_nk, ag_bus.ag_weight_base, ag_bus.ag_neuro_rbase, ag_bus.ag_neuro_wbase};
    endfunction

    task automatic cfg_write(input int a, input logic [31:0] v);
        cfg_we   = 1'b1;
        cfg_addr = 3'(a);
        {cfg_nk, cfg_wbase, cfg_rbase, cfg_wrbase} = v;
        @(negedge clk);
        cfg_we = 1'b0;
        tbl[a] = v;
    endtask

    // One full run. Model: busy = PRIME + sum(LOAD + RUN_i + DRAIN) + DONE, descriptors in order.
    task automatic do_run(input int nl, input bit stale, input bit poke, input int fixed_r,
                          input bit wr0);
        int          rr [MaxL];
        int          exp_busy = 2, exp_mac = 0;
        int          busy_c = 0, mac_c = 0, drain_c = 0, done_c = 0, lay = 0, k = 0, cyc = 0;
        bit          seen_done = 0;
        logic [31:0] got [$];
        logic [31:0] nd;
        for (int i = 1; i < nl; i++) begin
            rr[i] = stale ? 2 : ((fixed_r != 0) ? fixed_r : int'($urandom_range(2, 6)));
            exp_busy += 1 + rr[i] + Drain;
            exp_mac  += rr[i];
        end
        start      = 1'b1;
        num_layers = 4'(nl);
        if (wr0) begin
            nd       = $urandom;
            cfg_we   = 1'b1;
            cfg_addr = '0;
            {cfg_nk, cfg_wbase, cfg_rbase, cfg_wrbase} = nd;
            tbl[0]   = nd;
        end
        @(negedge clk);
        start  = 1'b0;
        cfg_we = 1'b0;
        while (!seen_done && cyc < 400) begin
            busy_c += int'(busy);
            if (ag_bus.ag_read) begin
                got.push_back({ag_bus.ag_nk, ag_bus.ag_weight_base, ag_bus.ag_neuro_rbase,
                               ag_bus.ag_neuro_wbase});
            end
            if (mac_clear) begin
                lay++;
                k = 0;
                chk("layer_idx at load", 64'(layer_idx), 64'(lay));
            end
            if (mac_en) begin
                k++;
                mac_c++;
            end
            if (busy && !ag_bus.ag_read && !mac_en && !done) drain_c++;
            if (done) begin
                done_c++;
                seen_done = 1;
            end
            ag_bus.ag_finished = stale ? 1'b1 : (mac_en && lay < MaxL && k >= rr[lay]);
            if (poke) begin
                if (cyc == 3) begin
                    start    = 1'b1;
                    cfg_we   = 1'b1;
                    cfg_addr = 3'd1;
                    {cfg_nk, cfg_wbase, cfg_rbase, cfg_wrbase} = ~tbl[1];
                end else begin
                    start  = 1'b0;
                    cfg_we = 1'b0;
                end
            end
            cyc++;
            @(negedge clk);
        end
        start  = 1'b0;
        cfg_we = 1'b0;
        ag_bus.ag_finished = 1'b0;
        if (!seen_done) chk("done within budget", 64'd0, 64'd1);
        chk("busy cycles", 64'(busy_c), 64'(exp_busy));
        chk("ag_read count", 64'(got.size()), 64'(nl));
        for (int i = 0; i < got.size() && i < nl; i++) chk("descriptor", 64'(got[i]), 64'(tbl[i]));
        chk("mac_clear count", 64'(lay), 64'(nl - 1));
        chk("mac_en cycles", 64'(mac_c), 64'(exp_mac));
        chk("drain cycles", 64'(drain_c), 64'((nl - 1) * Drain));
        chk("done pulses", 64'(done_c), 64'd1);
        chk("idle after done", 64'({busy, done, ag_bus.ag_read, mac_en, error}), 64'd0);
`ifdef LAYER_SEQ_CYCLE_CNT_EN
        chk("run_cycles", 64'(run_cycles), 64'(exp_busy + 1));
`endif
    endtask

    initial begin
        vec_t vecs [6];
        int   cnt, guard;
        vecs[0] = '{nl: 1,  err: 1'b1, bsy: 1'b0};
        vecs[1] = '{nl: 9,  err: 1'b1, bsy: 1'b0};
        vecs[2] = '{nl: 2,  err: 1'b0, bsy: 1'b1};
        vecs[3] = '{nl: 0,  err: 1'b1, bsy: 1'b0};
        vecs[4] = '{nl: 8,  err: 1'b0, bsy: 1'b1};
        vecs[5] = '{nl: 15, err: 1'b1, bsy: 1'b0};
        ag_bus.ag_finished = 1'b0;

        repeat (3) @(negedge clk);
        chk("outputs in reset", out_vec(), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("outputs after reset", out_vec(), 64'd0);

        cfg_write(0, {8'd4, 8'h10, 8'h20, 8'h30});
        cfg_write(1, {8'd3, 8'h11, 8'h21, 8'h31});
        cfg_write(2, {8'd2, 8'h12, 8'h22, 8'h32});
        for (int i = 3; i < MaxL; i++) cfg_write(i, $urandom);

        do_run(3, 1'b0, 1'b0, 0, 1'b0);   // Nk 4,3,2
        do_run(4, 1'b1, 1'b0, 0, 1'b0);   // finished held high: RUN=2, DRAIN=Drain

        foreach (vecs[v]) begin
            start      = 1'b1;
            num_layers = 4'(vecs[v].nl);
            @(negedge clk);
            start = 1'b0;
            chk("start error", 64'(error), 64'(vecs[v].err));
            chk("start busy", 64'(busy), 64'(vecs[v].bsy));
            chk("start ag_read", 64'(ag_bus.ag_read), 64'(vecs[v].bsy));
            cnt = 0;
            if (vecs[v].bsy) begin
                ag_bus.ag_finished = 1'b1;
                guard = 0;
                while (busy && guard < 200) begin
                    cnt += int'(done);
                    guard++;
                    @(negedge clk);
                end
                ag_bus.ag_finished = 1'b0;
                chk("valid start done once", 64'(cnt), 64'd1);
            end else begin
                repeat (4) begin
                    cnt += int'(busy | done | ag_bus.ag_read);
                    @(negedge clk);
                end
                chk("bad start stays idle", 64'(cnt), 64'd0);
                chk("error sticky", 64'(error), 64'd1);
            end
        end

        do_run(3, 1'b0, 1'b1, 0, 1'b0);   // start + cfg_we while busy are ignored

        // Reset during RUN of layer 2, then a fresh run from layer 1.
        start      = 1'b1;
        num_layers = 4'd3;
        @(negedge clk);
        start = 1'b0;
        ag_bus.ag_finished = 1'b1;
        guard = 0;
        while (!(mac_en && layer_idx == 3'd2) && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        chk("reached layer 2 run", 64'(guard < 100), 64'd1);
        #2 reset_n = 1'b0;
        #1 chk("outputs on mid-run reset", out_vec(), 64'd0);
        ag_bus.ag_finished = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_run(3, 1'b0, 1'b0, 0, 1'b0);

        do_run(2, 1'b0, 1'b0, 5, 1'b1);   // 5-cycle RUN, entry 0 written in the start cycle
`ifdef LAYER_SEQ_CYCLE_CNT_EN
        chk("run_cycles 2-layer", 64'(run_cycles), 64'd11);
`endif

        for (int t = 0; t < 6; t++) begin
            cfg_write(int'($urandom_range(0, MaxL - 1)), $urandom);
            do_run(int'($urandom_range(2, MaxL)), 1'b0, 1'($urandom % 2), 0, 1'($urandom % 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
